// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32-entry register file with write-first bypass,
// committed-write counter and sticky illegal-select flag.
module writeback_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteW,
    input  logic [1:0]            ResultSrcW,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic [DATA_WIDTH-1:0] ALUResultW,
    input  logic [DATA_WIDTH-1:0] ReadDataW,
    input  logic [DATA_WIDTH-1:0] PCPlus4W,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [CNT_WIDTH-1:0]  WriteCount,
    output logic                  IllegalSrc
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [1:0] SRC_ILLEGAL = 2'b11;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [CNT_WIDTH-1:0]  write_count;
    logic                  illegal_src;
    logic                  commit;
    logic                  illegal_access;

    function automatic logic [DATA_WIDTH-1:0] select_result(
        input logic [1:0]            src,
        input logic [DATA_WIDTH-1:0] alu,
        input logic [DATA_WIDTH-1:0] load,
        input logic [DATA_WIDTH-1:0] link
    );
        case (src)
            2'b00:   return alu;
            2'b01:   return load;
            2'b10:   return link;
            default: return '0;
        endcase
    endfunction

    assign ResultW = select_result(ResultSrcW, ALUResultW, ReadDataW, PCPlus4W);

    // Gating with rst_n keeps the bypass path from leaking data while the file is held clear.
    assign commit = rst_n && RegWriteW && (RdW != '0) && (ResultSrcW != SRC_ILLEGAL);
    assign illegal_access = RegWriteW && (ResultSrcW == SRC_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[RdW] <= ResultW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_count <= '0;
            illegal_src <= 1'b0;
        end else begin
            if (commit) begin
                write_count <= write_count + CNT_WIDTH'(1);
            end
            if (illegal_access) begin
                illegal_src <= 1'b1;
            end
        end
    end

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != '0) begin
            RD1 = (commit && (A1 == RdW)) ? ResultW : regs[A1];
        end
        if (A2 != '0) begin
            RD2 = (commit && (A2 == RdW)) ? ResultW : regs[A2];
        end
    end

    assign WriteCount = write_count;
    assign IllegalSrc = illegal_src;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: expectations queued at drive time, popped at sample time.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [3:0]  WriteCount;
    logic        IllegalSrc;

    writeback_regfile #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .ResultSrcW(ResultSrcW),
        .RdW       (RdW),
        .ALUResultW(ALUResultW),
        .ReadDataW (ReadDataW),
        .PCPlus4W  (PCPlus4W),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .ResultW   (ResultW),
        .WriteCount(WriteCount),
        .IllegalSrc(IllegalSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drv(input logic we, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] load,
                       input logic [31:0] link, input logic [4:0] a1, input logic [4:0] a2);
        RegWriteW  = we;
        ResultSrcW = src;
        RdW        = rd;
        ALUResultW = alu;
        ReadDataW  = load;
        PCPlus4W   = link;
        A1         = a1;
        A2         = a2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 2'b00, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        drv(0, 2'b00, 0, 0, 0, 0, 5, 31);
        push("reset_rd1", 0); push("reset_rd2", 0);
        push("reset_cnt", 0); push("reset_ill", 0);
        #2;
        chk(RD1); chk(RD2); chk({28'b0, WriteCount}); chk({31'b0, IllegalSrc});
        rst_n = 1'b1;

        // Source-select writes
        @(negedge clk);
        drv(1, 2'b00, 3, 32'h1234, 32'h0, 32'h0, 0, 0);
        push("res_alu", 32'h1234);
        #2; chk(ResultW);

        @(negedge clk);
        drv(1, 2'b01, 4, 32'h0, 32'hDEADBEEF, 32'h0, 3, 0);
        push("res_load", 32'hDEADBEEF); push("reg3", 32'h1234);
        #2; chk(ResultW); chk(RD1);

        @(negedge clk);
        drv(1, 2'b10, 1, 32'h0, 32'h0, 32'h104, 4, 0);
        push("res_pc4", 32'h104); push("reg4", 32'hDEADBEEF);
        #2; chk(ResultW); chk(RD1);

        @(negedge clk);
        drv(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 1, 3);
        push("reg1", 32'h104); push("reg3_again", 32'h1234); push("cnt_after3", 3);
        #2; chk(RD1); chk(RD2); chk({28'b0, WriteCount});

        // Same-cycle bypass on both ports
        @(negedge clk);
        drv(1, 2'b00, 7, 32'hA5A5A5A5, 32'h0, 32'h0, 7, 7);
        push("bypass_rd1", 32'hA5A5A5A5); push("bypass_rd2", 32'hA5A5A5A5);
        #2; chk(RD1); chk(RD2);

        @(negedge clk);
        drv(0, 2'b00, 7, 32'h0, 32'h0, 32'h0, 7, 7);
        push("reg7_rd1", 32'hA5A5A5A5); push("reg7_rd2", 32'hA5A5A5A5); push("cnt_after4", 4);
        #2; chk(RD1); chk(RD2); chk({28'b0, WriteCount});

        // x0 stays zero
        @(negedge clk);
        drv(1, 2'b00, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0);
        push("x0_same_cycle", 0); push("x0_result", 32'hFFFFFFFF);
        #2; chk(RD1); chk(ResultW);

        @(negedge clk);
        drv(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        push("x0_after", 0); push("cnt_x0", 4);
        #2; chk(RD1); chk({28'b0, WriteCount});

        // Illegal select: first ignored without write enable, then with it
        @(negedge clk);
        drv(1, 2'b00, 9, 32'h55, 32'h0, 32'h0, 0, 0);
        #2;

        @(negedge clk);
        drv(0, 2'b11, 9, 32'h77, 32'h0, 32'h0, 9, 0);
        push("reg9", 32'h55); push("cnt_reg9", 5);
        #2; chk(RD1); chk({28'b0, WriteCount});

        @(negedge clk);
        drv(1, 2'b11, 9, 32'h77, 32'h66, 32'h88, 9, 0);
        push("ill_ignored_no_we", 0); push("ill_result_zero", 0); push("ill_no_bypass", 32'h55);
        #2; chk({31'b0, IllegalSrc}); chk(ResultW); chk(RD1);

        @(negedge clk);
        drv(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 9, 0);
        push("ill_set", 1); push("ill_reg9_kept", 32'h55); push("ill_cnt", 5);
        #2; chk({31'b0, IllegalSrc}); chk(RD1); chk({28'b0, WriteCount});

        @(negedge clk);
        push("ill_sticky", 1);
        #2; chk({31'b0, IllegalSrc});

        // Counter wrap: 11 writes take 5 -> 0
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drv(1, 2'b00, 5'(10 + i), 32'h1000 + 32'(i), 32'h0, 32'h0, 0, 0);
        end
        @(negedge clk);
        drv(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 10, 20);
        push("wrap_cnt", 0); push("reg10", 32'h1000); push("reg20", 32'h100A);
        #2; chk({28'b0, WriteCount}); chk(RD1); chk(RD2);

        @(negedge clk);
        drv(1, 2'b01, 21, 32'h0, 32'h2121, 32'h0, 0, 0);
        @(negedge clk);
        drv(1, 2'b10, 22, 32'h0, 32'h0, 32'h2222, 21, 0);
        @(negedge clk);
        drv(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 3, 22);
        push("cnt_after_wrap", 2); push("pre_reset_reg3", 32'h1234); push("reg22", 32'h2222);
        #2; chk({28'b0, WriteCount}); chk(RD1); chk(RD2);

        // Async reset between edges
        rst_n = 1'b0;
        push("arst_rd1", 0); push("arst_rd2", 0); push("arst_cnt", 0); push("arst_ill", 0);
        #1; chk(RD1); chk(RD2); chk({28'b0, WriteCount}); chk({31'b0, IllegalSrc});

        // Edge under reset performs no write
        @(negedge clk);
        drv(1, 2'b00, 5, 32'h99, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        drv(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5, 0);
        push("reset_edge_nowrite", 0); push("reset_edge_cnt", 0);
        #2; chk(RD1); chk({28'b0, WriteCount});

        // First edge after release writes
        rst_n = 1'b1;
        drv(1, 2'b00, 5, 32'h77, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        drv(0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5, 0);
        push("first_write_after_rst", 32'h77); push("cnt_after_rst", 1);
        #2; chk(RD1); chk({28'b0, WriteCount});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the final result from ALU, load data or PC+4, and commits it to a 32-entry architectural register file.
- Serves the decode stage's two combinational read ports, with same-cycle write-to-read bypass.
- Exports the selected result for the forwarding unit, plus a committed-write counter and a sticky illegal-select flag for debug.

Parameters:
- DATA_WIDTH, 32, width of registers and datapath.
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- CNT_WIDTH, 32, width of the committed-write counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- RegWriteW  input  1  write enable from the writeback stage.
- ResultSrcW  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 illegal.
- RdW  input  ADDR_WIDTH  destination register index.
- ALUResultW  input  DATA_WIDTH  ALU result.
- ReadDataW  input  DATA_WIDTH  load data.
- PCPlus4W  input  DATA_WIDTH  link address.
- A1  input  ADDR_WIDTH  read port 1 index (decode stage).
- A2  input  ADDR_WIDTH  read port 2 index (decode stage).
- RD1  output  DATA_WIDTH  read port 1 data.
- RD2  output  DATA_WIDTH  read port 2 data.
- ResultW  output  DATA_WIDTH  selected writeback value, to the forwarding mux.
- WriteCount  output  CNT_WIDTH  number of committed register writes.
- IllegalSrc  output  1  sticky flag: an illegal select was seen with a write enabled.

Behaviour:
- Clocking and reset: single clock domain clk. Reset is asynchronous, active-low on rst_n. While rst_n=0:
  - all registers x0..x31 read 0;
  - WriteCount=0;
  - IllegalSrc=0.
- ResultW is purely combinational:
  - 00 gives ALUResultW;
  - 01 gives ReadDataW;
  - 10 gives PCPlus4W;
  - 11 gives 0.
- Commit condition: WE = RegWriteW && (RdW != 0) && (ResultSrcW != 11).
- On the rising edge of clk with WE=1, reg[RdW] <= ResultW. Write latency is one edge.
- x0 is hardwired to zero:
  - writes to index 0 are dropped;
  - RD1/RD2 return 0 for index 0 regardless of bypass.
- Reads are combinational, with write-first bypass. If WE=1 and A1==RdW (nonzero), RD1=ResultW in the same cycle; otherwise RD1=reg[A1]. RD2 and A2 follow the same rule.
- A1==A2 is legal, and both ports return the same value, bypass included.
- WriteCount increments by 1 on each edge where WE=1. It wraps from all-ones to 0 with no flag. RegWriteW with RdW=0 does not count.
- IllegalSrc is set on an edge where RegWriteW=1 and ResultSrcW=11. Such an access performs no write and no count. The flag holds until reset.
- ResultSrcW=11 with RegWriteW=0 is ignored, and the flag is not set.
- Reset asserted mid-operation: the register file clears immediately, and any edge coincident with active reset performs no write.
- Reset deassertion: the first write can occur on the first rising edge with rst_n=1.
- Inputs are sampled only at edges. Glitches between edges affect only the combinational outputs.

Test Plan:
- Reset then read: assert rst_n=0, release, set A1=5, A2=31 -> RD1=0, RD2=0, WriteCount=0, IllegalSrc=0.
- Source select writes, each with RegWriteW=1, reading back on the following cycle:
  - ResultSrcW=00, ALUResultW=0x1234, RdW=3 -> reg3=0x1234;
  - ResultSrcW=01, ReadDataW=0xDEADBEEF, RdW=4 -> reg4=0xDEADBEEF;
  - ResultSrcW=10, PCPlus4W=0x104, RdW=1 -> reg1=0x104;
  - WriteCount=3 after the three writes.
- Same-cycle bypass: write RdW=7, ALU=0xA5A5A5A5 with A1=7, A2=7 in that cycle -> RD1=RD2=0xA5A5A5A5 before the edge; after the edge, with RegWriteW=0, both still read 0xA5A5A5A5.
- x0 protection: RegWriteW=1, RdW=0, ALU=0xFFFFFFFF, A1=0 -> RD1=0 in that cycle and after; WriteCount unchanged.
- Illegal select: RegWriteW=1, ResultSrcW=11, RdW=9, with reg9 previously 0x55 -> reg9 stays 0x55, ResultW=0, IllegalSrc=1 and stays 1; WriteCount unchanged.
- Async reset mid-stream, with CNT_WIDTH=4 for wrap:
  - perform 16 writes -> WriteCount wraps to 0;
  - perform 2 more -> WriteCount=2;
  - drop rst_n between edges -> all reads and WriteCount go to 0 immediately, without a clock edge.
